// File: rtl/handshake_ring_buf.sv
// DEPTH-entry circular valid/ready buffer with fill level, almost-full flag,
// high-watermark and synchronous flush. Handshake readiness depends only on state and flush.
module handshake_ring_buf #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned AFULL_LVL  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    up_valid,
    input  logic [WORD_WIDTH-1:0]   up_data,
    output logic                    up_ready,
    output logic                    down_valid,
    output logic [WORD_WIDTH-1:0]   down_data,
    input  logic                    down_ready,
    output logic                    my_accept,
    output logic                    my_transmit,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  level_max
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  acc;
    logic                  xmt;

    // Handshake qualifiers come from registered occupancy only; flush blocks both sides.
    always_comb begin
        up_ready   = ~flush & (count != CW'(DEPTH));
        down_valid = ~flush & (count != '0);
        acc        = up_valid & up_ready;
        xmt        = down_valid & down_ready;
        count_nxt  = count;
        if (acc && !xmt) begin
            count_nxt = count + CW'(1);
        end else if (!acc && xmt) begin
            count_nxt = count - CW'(1);
        end
    end

    assign down_data   = mem[rd_ptr];
    assign my_accept   = acc;
    assign my_transmit = xmt;
    assign level       = count;
    assign almost_full = (count >= CW'(AFULL_LVL));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            level_max <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            // Contents are left in place; pointers and counters restart.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            level_max <= '0;
        end else begin
            if (acc) begin
                mem[wr_ptr] <= up_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (xmt) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            if (count_nxt > level_max) begin
                level_max <= count_nxt;
            end
        end
    end

endmodule

// File: tb/tb_handshake_ring_buf.sv
// Directed vector table plus hand sequences and a scoreboarded random run
// for handshake_ring_buf at DEPTH=4, AFULL_LVL=3.
module tb_handshake_ring_buf;

    localparam int unsigned WW = 32;
    localparam int unsigned NV = 19;

    logic          clk = 1'b0;
    logic          rst_n, flush, up_valid, down_ready;
    logic [WW-1:0] up_data;
    logic          up_ready, down_valid, my_accept, my_transmit, almost_full;
    logic [WW-1:0] down_data;
    logic [2:0]    level, level_max;

    int total = 0;
    int bad   = 0;

    handshake_ring_buf #(.WORD_WIDTH(WW), .DEPTH(4), .AFULL_LVL(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
        .down_valid(down_valid), .down_data(down_data), .down_ready(down_ready),
        .my_accept(my_accept), .my_transmit(my_transmit),
        .level(level), .almost_full(almost_full), .level_max(level_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fl;
        logic          uv;
        logic [WW-1:0] ud;
        logic          dr;
        logic          e_ur;
        logic          e_dv;
        logic [WW-1:0] e_dd;
        logic          chk_dd;
        logic          e_acc;
        logic          e_xmt;
        logic [2:0]    e_lvl;
        logic          e_af;
        logic [2:0]    e_lmax;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic fl, input logic uv, input logic [WW-1:0] ud,
                                input logic dr, input logic ur, input logic dv,
                                input logic [WW-1:0] dd, input logic cdd, input logic ac,
                                input logic xm, input logic [2:0] lv, input logic af,
                                input logic [2:0] lm);
        vec_t v;
        v.fl = fl; v.uv = uv; v.ud = ud; v.dr = dr;
        v.e_ur = ur; v.e_dv = dv; v.e_dd = dd; v.chk_dd = cdd;
        v.e_acc = ac; v.e_xmt = xm; v.e_lvl = lv; v.e_af = af; v.e_lmax = lm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic uv, input logic [WW-1:0] ud, input logic dr);
        flush = fl; up_valid = uv; up_data = ud; down_ready = dr;
    endtask

    // Settle after the inputs change, then let one rising edge pass.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [WW-1:0] sb [$];
    logic [WW-1:0] got [$];
    int n_acc, n_xmt, model_cnt;
    logic m_acc, m_xmt, hold;
    logic [WW-1:0] nxt;

    initial begin
        // Occupancy walkthrough: fill, full boundary, read-frees-slot, drain, flush, empty boundary.
        vecs[0]  = mk(0,0,32'h00,0, 1,0,32'h00,1, 0,0,3'd0,0,3'd0);
        vecs[1]  = mk(0,1,32'hA0,0, 1,0,32'h00,1, 1,0,3'd0,0,3'd0);
        vecs[2]  = mk(0,1,32'hA1,0, 1,1,32'hA0,1, 1,0,3'd1,0,3'd1);
        vecs[3]  = mk(0,1,32'hA2,0, 1,1,32'hA0,1, 1,0,3'd2,0,3'd2);
        vecs[4]  = mk(0,1,32'hA3,0, 1,1,32'hA0,1, 1,0,3'd3,1,3'd3);
        vecs[5]  = mk(0,1,32'hA4,0, 0,1,32'hA0,1, 0,0,3'd4,1,3'd4);
        vecs[6]  = mk(0,1,32'hA4,0, 0,1,32'hA0,1, 0,0,3'd4,1,3'd4);
        vecs[7]  = mk(0,1,32'hA4,1, 0,1,32'hA0,1, 0,1,3'd4,1,3'd4);
        vecs[8]  = mk(0,1,32'hA4,0, 1,1,32'hA1,1, 1,0,3'd3,1,3'd4);
        vecs[9]  = mk(0,0,32'h00,1, 0,1,32'hA1,1, 0,1,3'd4,1,3'd4);
        vecs[10] = mk(0,0,32'h00,1, 1,1,32'hA2,1, 0,1,3'd3,1,3'd4);
        vecs[11] = mk(0,0,32'h00,1, 1,1,32'hA3,1, 0,1,3'd2,0,3'd4);
        vecs[12] = mk(0,0,32'h00,1, 1,1,32'hA4,1, 0,1,3'd1,0,3'd4);
        vecs[13] = mk(0,0,32'h00,1, 1,0,32'h00,0, 0,0,3'd0,0,3'd4);
        vecs[14] = mk(1,0,32'h00,0, 0,0,32'h00,0, 0,0,3'd0,0,3'd4);
        vecs[15] = mk(0,0,32'h00,0, 1,0,32'h00,0, 0,0,3'd0,0,3'd0);
        vecs[16] = mk(0,1,32'h55,1, 1,0,32'h00,0, 1,0,3'd0,0,3'd0);
        vecs[17] = mk(0,0,32'h00,1, 1,1,32'h55,1, 0,1,3'd1,0,3'd1);
        vecs[18] = mk(0,0,32'h00,1, 1,0,32'h00,0, 0,0,3'd0,0,3'd1);

        rst_n = 1'b0;
        drive(0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            drive(vecs[i].fl, vecs[i].uv, vecs[i].ud, vecs[i].dr);
            #4;
            chk($sformatf("v%0d up_ready", i), WW'(up_ready), WW'(vecs[i].e_ur));
            chk($sformatf("v%0d down_valid", i), WW'(down_valid), WW'(vecs[i].e_dv));
            if (vecs[i].chk_dd) chk($sformatf("v%0d down_data", i), down_data, vecs[i].e_dd);
            chk($sformatf("v%0d my_accept", i), WW'(my_accept), WW'(vecs[i].e_acc));
            chk($sformatf("v%0d my_transmit", i), WW'(my_transmit), WW'(vecs[i].e_xmt));
            chk($sformatf("v%0d level", i), WW'(level), WW'(vecs[i].e_lvl));
            chk($sformatf("v%0d almost_full", i), WW'(almost_full), WW'(vecs[i].e_af));
            chk($sformatf("v%0d level_max", i), WW'(level_max), WW'(vecs[i].e_lmax));
            tick();
        end

        // Flush with a loaded buffer and both sides requesting.
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'hB0 + WW'(i), 0);
            tick();
        end
        drive(1, 1, 32'hBB, 1);
        #4;
        chk("flush acc", WW'(my_accept), 0);
        chk("flush xmt", WW'(my_transmit), 0);
        chk("flush up_ready", WW'(up_ready), 0);
        chk("flush down_valid", WW'(down_valid), 0);
        tick();
        drive(0, 1, 32'h77, 0);
        #4;
        chk("post-flush level", WW'(level), 0);
        chk("post-flush level_max", WW'(level_max), 0);
        chk("post-flush down_valid", WW'(down_valid), 0);
        chk("post-flush acc 77", WW'(my_accept), 1);
        tick();
        drive(0, 0, '0, 1);
        #4;
        chk("77 down_data", down_data, 32'h77);
        chk("77 xmt", WW'(my_transmit), 1);
        tick();
        chk("after 77 down_valid", WW'(down_valid), 0);

        // Steady streaming: one beat per cycle, ordering preserved, pointers wrap.
        n_acc = 0; n_xmt = 0;
        for (int c = 0; c < 20; c++) begin
            drive(0, 1, 32'hC00 + WW'(n_acc), 1);
            #4;
            if (c > 0) chk($sformatf("stream level c%0d", c), WW'(level), 1);
            if (my_accept) begin sb.push_back(up_data); n_acc++; end
            if (my_transmit) begin got.push_back(down_data); n_xmt++; end
            tick();
        end
        chk("stream accepts", WW'(n_acc), 20);
        chk("stream transmits", WW'(n_xmt), 19);
        for (int i = 0; i < 19; i++) begin
            chk($sformatf("stream order %0d", i), got[i], 32'hC00 + WW'(i));
        end
        sb.delete(); got.delete();
        drive(0, 0, '0, 1);
        tick();
        chk("stream drained", WW'(level), 0);

        // Mid-operation reset beats flush and a pending handshake; mem is cleared.
        drive(0, 1, 32'hD0, 0); tick();
        drive(0, 1, 32'hD1, 0); tick();
        rst_n = 1'b0;
        drive(1, 1, 32'hD2, 1);
        tick();
        rst_n = 1'b1;
        drive(0, 0, '0, 0);
        #4;
        chk("rst level", WW'(level), 0);
        chk("rst level_max", WW'(level_max), 0);
        chk("rst down_valid", WW'(down_valid), 0);
        chk("rst down_data", down_data, 0);
        chk("rst up_ready", WW'(up_ready), 1);
        tick();

        // Random valid/ready against a queue model; valid/data held until accepted.
        n_acc = 0; n_xmt = 0; hold = 0; nxt = 0;
        for (int c = 0; c < 2000; c++) begin
            if (!hold) begin
                up_valid = 1'($urandom_range(1, 0));
                nxt = nxt + 1;
                up_data = nxt;
            end
            flush = 0;
            down_ready = 1'($urandom_range(1, 0));
            #4;
            model_cnt = sb.size();
            m_acc = up_valid && (model_cnt != 4);
            m_xmt = down_ready && (model_cnt != 0);
            chk("rnd level", WW'(level), WW'(model_cnt));
            chk("rnd acc", WW'(my_accept), WW'(m_acc));
            chk("rnd xmt", WW'(my_transmit), WW'(m_xmt));
            if (level > 3'd4) chk("rnd level bound", WW'(level), 4);
            if (m_xmt) chk("rnd data", down_data, sb.pop_front());
            if (m_acc) sb.push_back(up_data);
            if (my_accept) n_acc++;
            if (my_transmit) n_xmt++;
            hold = up_valid && !m_acc;
            tick();
        end
        drive(0, 0, '0, 0);
        #4;
        chk("rnd acc-xmt vs level", WW'(n_acc - n_xmt), WW'(level));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
